// File: rtl/window_assembler.sv
// window_assembler
//   Consumer end of a line buffer. Each accepted pixel brings a vertical
//   column of W_H pixels (newest row in the low byte). The column is shifted
//   into a W_H x W_W window, and the raster position of that pixel is tracked.
//   A registered window is presented one cycle after each accepted pixel.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   en         in   column valid; one pixel accepted per cycle with en=1
//   sof        in   start of frame, sampled only when en=1
//   col_in     in   W_H*8     byte r = row N-r of the current column
//   win        out  W_H*W_W*8 byte (r*W_W+c) = row N-r, column M-c (c=0 newest)
//   win_valid  out  one-cycle strobe: win is a usable window
//   win_col    out  column index of the newest pixel in win
//   win_row    out  row index of the newest pixel in win
//
// Optional build macro WIN_ZERO_PAD_EN: win_valid follows every accepted
// pixel, and window columns/rows that fall outside the image are zeroed on
// the output (the shift register itself keeps raw data).
module window_assembler #(
   parameter int W_H      = 3,
   parameter int W_W      = 3,
   parameter int ROW_LEN  = 10,
   parameter int NUM_ROWS = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          sof,
   input  logic [W_H*8-1:0]              col_in,
   output logic [W_H*W_W*8-1:0]          win,
   output logic                          win_valid,
   output logic [$clog2(ROW_LEN)-1:0]    win_col,
   output logic [$clog2(NUM_ROWS)-1:0]   win_row
);

   localparam int CW = $clog2(ROW_LEN);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int WB = W_H * W_W * 8;

   localparam logic [CW-1:0] COL_LAST = CW'(ROW_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(W_W - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(W_H - 1);

   logic [WB-1:0] sr_q, sr_d;
   logic [CW-1:0] col_cnt_q, col_cnt_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [CW-1:0] win_col_q, win_col_d;
   logic [RW-1:0] win_row_q, win_row_d;
   logic          win_valid_q, win_valid_d;

   // Position of the pixel being accepted this cycle (sof overrides counters)
   logic [CW-1:0] pos_col;
   logic [RW-1:0] pos_row;

   always_comb begin
      sr_d        = sr_q;
      col_cnt_d   = col_cnt_q;
      row_cnt_d   = row_cnt_q;
      win_col_d   = win_col_q;
      win_row_d   = win_row_q;
      win_valid_d = 1'b0;
      pos_col     = sof ? '0 : col_cnt_q;
      pos_row     = sof ? '0 : row_cnt_q;

      if (en) begin
         // Horizontal shift: column c takes column c-1, column 0 takes col_in
         for (int r = 0; r < W_H; r++) begin
            for (int c = 0; c < W_W; c++) begin
               if (c == 0)
                  sr_d[(r*W_W)*8 +: 8] = col_in[r*8 +: 8];
               else
                  sr_d[(r*W_W+c)*8 +: 8] = sr_q[(r*W_W+c-1)*8 +: 8];
            end
         end

         win_col_d = pos_col;
         win_row_d = pos_row;

         if (pos_col == COL_LAST) begin
            col_cnt_d = '0;
            row_cnt_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
         end else begin
            col_cnt_d = pos_col + 1'b1;
            row_cnt_d = pos_row;
         end

`ifdef WIN_ZERO_PAD_EN
         win_valid_d = 1'b1;
`else
         // Full window only: enough columns in this row and enough rows above
         win_valid_d = (pos_col >= COL_MIN) && (pos_row >= ROW_MIN);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q        <= '0;
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         win_col_q   <= '0;
         win_row_q   <= '0;
         win_valid_q <= 1'b0;
      end else begin
         sr_q        <= sr_d;
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         win_col_q   <= win_col_d;
         win_row_q   <= win_row_d;
         win_valid_q <= win_valid_d;
      end
   end

`ifdef WIN_ZERO_PAD_EN
   // Output-side padding: the shift register keeps raw (possibly stale)
   // pixels, only the presented window is masked by the reported position.
   logic [WB-1:0] win_pad;

   always_comb begin
      win_pad = sr_q;
      for (int r = 0; r < W_H; r++) begin
         for (int c = 0; c < W_W; c++) begin
            if ((int'(win_col_q) < c) || (int'(win_row_q) < r))
               win_pad[(r*W_W+c)*8 +: 8] = 8'h00;
         end
      end
   end

   assign win = win_pad;
`else
   assign win = sr_q;
`endif

   assign win_valid = win_valid_q;
   assign win_col   = win_col_q;
   assign win_row   = win_row_q;

endmodule

// File: doc/window_assembler.md
Name: window_assembler

Overview:
- Consumer end of component_buffer: accepts the per-pixel vertical column (W_H rows, newest row in the low byte) and assembles a W_H x W_W pixel window by horizontal shifting.
- Tracks raster position with column and row counters; flags when the window lies fully inside the image.
- Feeds downstream 2D kernels (filters, Harris/corner stages) with one registered window per accepted pixel.

Parameters:
- W_H, 3, window height in rows; must equal the component_buffer W_H feeding col_in.
- W_W, 3, window width in columns, >=1.
- ROW_LEN, 10, pixels per row; column counter wraps at ROW_LEN-1.
- NUM_ROWS, 8, rows per frame; row counter wraps at NUM_ROWS-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  column valid; one accepted pixel per cycle with en=1.
- sof  in  1  start of frame; sampled only when en=1.
- col_in  in  W_H*8  pixel column; byte r = [r*8+7:r*8] = row N-r.
- win  out  W_H*W_W*8  window; byte (r*W_W+c) = row N-r, column M-c (c=0 newest).
- win_valid  out  1  window valid strobe.
- win_col  out  $clog2(ROW_LEN)  column index of newest pixel in win.
- win_row  out  $clog2(NUM_ROWS)  row index of newest pixel in win.

Behaviour:
- Reset (async, rst=1): win=0, win_valid=0, win_col=0, win_row=0, internal counters=0; next accepted pixel is col 0, row 0.
- Accept (en=1), registered, latency 1 cycle:
  - Shift the window one column: column c takes column c-1; column 0 takes col_in.
  - win_col/win_row take the position of the accepted pixel.
- Position counters:
  - sof=1 with en=1 forces position (0,0) for this pixel; the next pixel is (1,0).
  - Otherwise col = col+1; at ROW_LEN-1 col wraps to 0 and row increments.
  - Row wraps from NUM_ROWS-1 to 0.
  - sof with en=0 is ignored.
- win_valid:
  - Asserts for exactly one cycle after an accepted pixel with col >= W_W-1 and row >= W_H-1.
  - Deasserts on any cycle with en=0.
- Hold (en=0, blanking): win, win_col, win_row and counters are held; col_in contents are ignored.
- Row wrap: columns shifted in from the previous row remain in win at the start of a row. They are masked by win_valid (col < W_W-1) and not cleared.
- sof mid-row: counters restart immediately; window contents are kept, and win_valid is governed by the new position.
- Reset mid-frame: everything clears asynchronously; no window from before reset is ever flagged valid.
- Degenerate case W_W=1: win equals the registered col_in; the validity column condition is always true.

Optional Feature:
- Macro WIN_ZERO_PAD_EN.
- Defined:
  - win_valid asserts for every accepted pixel (latency 1).
  - Window column c is forced to zero when col < c.
  - Window row r is forced to zero when row < r.
  - Padding is applied on the output only; the shift register still holds raw data.
- Undefined: no padding logic; win is raw shift-register content, and win_valid follows the full-window rule above.

Test Plan:
- Stimulus for all scenarios: W_H=3, W_W=3, ROW_LEN=10; 4 rows driven with bytes (row*0x10+i) for rows N, N-1, N-2 as component_buffer produces them, and 5 cycles en=0 between rows.
  - Required: exactly 16 win_valid pulses, at rows 2-3, cols 2-9.
  - Required: no pulse during blanking.
- Row 2, col 2 accepted -> next cycle win_valid=1, win_row=2, win_col=2.
  - Row 0 bytes c0..c2 = 22,21,20; row 1 = 12,11,10; row 2 = 02,01,00.
- Row 3, col 0 accepted -> win_valid=0 and win_col=0.
  - Columns 1-2 still hold row 2's pixels 29/28 (stale, masked).
- Assert rst for 1 cycle mid-row 2 -> win=0 and win_valid=0 immediately.
  - The next pixel reports win_row=0, win_col=0, with no valid pulse until col>=2, row>=2.
- sof=1 with en at original row 3, col 5 -> win_row=0, win_col=0, win_valid=0; counting restarts from this pixel.
- With WIN_ZERO_PAD_EN and pixel (0,0) holding 0x00 -> win_valid=1.
  - win byte 0 = 00; all other bytes = 0.
  - Then pixel (1,0) -> bytes c0,c1 of row 0 = 01,00; every other byte = 0.
